// File: rtl/ibex_multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide front-end sequencer:
// unit operator codes, sequencer states and RV32M funct3 encodings.
package ibex_multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ibex_multdiv_decode.sv
// Combinational RV32M funct3 decoder: unit operator, operand signedness
// (bit 0 = a signed, bit 1 = b signed) and multiply/divide selection.
module ibex_multdiv_decode
  import ibex_multdiv_sequencer_pkg::*;
(
  input  logic [2:0] i_funct3,
  output logic [1:0] o_operator,
  output logic [1:0] o_signed_mode,
  output logic       o_is_div
);

  always_comb begin
    o_operator    = MD_OP_MULL;
    o_signed_mode = 2'b00;
    case (i_funct3)
      F3_MUL:    begin o_operator = MD_OP_MULL; o_signed_mode = 2'b00; end
      F3_MULH:   begin o_operator = MD_OP_MULH; o_signed_mode = 2'b11; end
      F3_MULHSU: begin o_operator = MD_OP_MULH; o_signed_mode = 2'b01; end
      F3_MULHU:  begin o_operator = MD_OP_MULH; o_signed_mode = 2'b00; end
      F3_DIV:    begin o_operator = MD_OP_DIV;  o_signed_mode = 2'b11; end
      F3_DIVU:   begin o_operator = MD_OP_DIV;  o_signed_mode = 2'b00; end
      F3_REM:    begin o_operator = MD_OP_REM;  o_signed_mode = 2'b11; end
      F3_REMU:   begin o_operator = MD_OP_REM;  o_signed_mode = 2'b00; end
      default:   begin o_operator = MD_OP_MULL; o_signed_mode = 2'b00; end
    endcase
  end

  assign o_is_div = o_operator[1];

endmodule

// File: rtl/ibex_multdiv_sequencer.sv
// Front-end sequencer for the fast mult/div unit: accepts a request, holds
// operands/controls, enables the unit until done and returns a tagged result.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | unit enabled, waiting for md_ready_i (watchdog running)
// DRAIN | killed op still enabled until the unit returns to idle
// RESP  | response held until rsp_ready_i
module ibex_multdiv_sequencer
  import ibex_multdiv_sequencer_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             kill_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  output logic             md_equal_to_zero_o,
  input  logic             md_ready_i,
  input  logic [31:0]      md_result_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [31:0]       r_op_a, r_op_b, r_result;
  logic [TAG_W-1:0]  r_tag;
  logic [1:0]        r_operator, r_signed_mode;
  logic              r_is_div, r_eq_zero, r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_operator, w_signed_mode;
  logic              w_is_div, w_accept, w_en, w_capture, w_tmo, w_cnt_tc;

  ibex_multdiv_decode u_decode (
    .i_funct3      (req_funct3_i),
    .o_operator    (w_operator),
    .o_signed_mode (w_signed_mode),
    .o_is_div      (w_is_div)
  );

  assign w_cnt_tc = (r_cnt == '0);
  assign w_accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    w_en        = 1'b0;
    w_capture   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = ~kill_i;
        if (req_valid_i && !kill_i) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_en = 1'b1;
        // A kill landing on the done cycle needs no drain: the unit is already idle.
        if (md_ready_i) begin
          if (kill_i) w_state_nxt = S_IDLE;
          else begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end else if (kill_i) begin
          w_state_nxt = S_DRAIN;
        end else if (w_cnt_tc) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_DRAIN: begin
        w_en = 1'b1;
        if (md_ready_i || w_cnt_tc) w_state_nxt = S_IDLE;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i & ~kill_i;
        if (kill_i)           w_state_nxt = S_IDLE;
        else if (rsp_ready_i) w_state_nxt = req_valid_i ? S_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_tag         <= '0;
      r_operator    <= '0;
      r_signed_mode <= '0;
      r_is_div      <= 1'b0;
      r_eq_zero     <= 1'b0;
      r_result      <= '0;
      r_err         <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_accept) begin
        r_op_a        <= req_op_a_i;
        r_op_b        <= req_op_b_i;
        r_tag         <= req_tag_i;
        r_operator    <= w_operator;
        r_signed_mode <= w_signed_mode;
        r_is_div      <= w_is_div;
        r_eq_zero     <= (req_op_b_i == 32'd0);
        r_cnt         <= CNT_LOAD;
      end else if (w_en && !w_cnt_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_result <= md_result_i;
        r_err    <= 1'b0;
      end else if (w_tmo) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  assign md_mult_en_o       = w_en & ~r_is_div;
  assign md_div_en_o        = w_en & r_is_div;
  assign md_operator_o      = r_operator;
  assign md_signed_mode_o   = r_signed_mode;
  assign md_op_a_o          = r_op_a;
  assign md_op_b_o          = r_op_b;
  assign md_equal_to_zero_o = r_eq_zero;
  assign rsp_result_o       = r_result;
  assign rsp_tag_o          = r_tag;
  assign rsp_err_o          = r_err;

endmodule

// File: tb/tb_ibex_multdiv_sequencer.sv
// Directed bench for ibex_multdiv_sequencer with a behavioural mult/div unit
// and a response scoreboard of expected result/tag/error.
module tb_ibex_multdiv_sequencer;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i, req_ready_o, kill_i;
  logic [2:0]       req_funct3_i;
  logic [31:0]      req_op_a_i, req_op_b_i;
  logic [TAG_W-1:0] req_tag_i, rsp_tag_o;
  logic             rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0]      rsp_result_o;
  logic             md_mult_en_o, md_div_en_o, md_equal_to_zero_o, md_ready_i;
  logic [1:0]       md_operator_o, md_signed_mode_o;
  logic [31:0]      md_op_a_o, md_op_b_o, md_result_i;

  always #5 clk = ~clk;

  ibex_multdiv_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_tag_i(req_tag_i),
    .kill_i(kill_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o), .md_operator_o(md_operator_o),
    .md_signed_mode_o(md_signed_mode_o), .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_equal_to_zero_o(md_equal_to_zero_o), .md_ready_i(md_ready_i), .md_result_i(md_result_i)
  );

  // Behavioural unit: counts enabled cycles, done on the last one of its latency.
  logic        u_stub = 1'b0;
  logic [5:0]  u_cnt;
  logic [5:0]  u_lat;
  logic        u_en;
  logic signed [65:0] u_ea, u_eb, u_prod;
  logic [31:0] u_res;

  assign u_en = md_mult_en_o | md_div_en_o;

  always_comb begin
    u_lat = 6'd0;
    case (md_operator_o)
      2'd0:    u_lat = 6'd3;
      2'd1:    u_lat = 6'd4;
      default: u_lat = md_equal_to_zero_o ? 6'd2 : 6'd37;
    endcase
    u_ea   = md_signed_mode_o[0] ? {{34{md_op_a_o[31]}}, md_op_a_o} : {34'b0, md_op_a_o};
    u_eb   = md_signed_mode_o[1] ? {{34{md_op_b_o[31]}}, md_op_b_o} : {34'b0, md_op_b_o};
    u_prod = u_ea * u_eb;
    u_res  = 32'h0;
    case (md_operator_o)
      2'd0: u_res = u_prod[31:0];
      2'd1: u_res = u_prod[63:32];
      2'd2: u_res = (md_op_b_o == 32'd0) ? 32'hFFFF_FFFF :
                    (md_signed_mode_o == 2'b11) ? 32'($signed(md_op_a_o) / $signed(md_op_b_o))
                                                : md_op_a_o / md_op_b_o;
      default: u_res = (md_op_b_o == 32'd0) ? md_op_a_o :
                       (md_signed_mode_o == 2'b11) ? 32'($signed(md_op_a_o) % $signed(md_op_b_o))
                                                   : md_op_a_o % md_op_b_o;
    endcase
    md_ready_i  = u_en && !u_stub && (u_cnt == u_lat - 6'd1);
    md_result_i = md_ready_i ? u_res : 32'hDEAD_BEEF;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    u_cnt <= 6'd0;
    else if (u_en) u_cnt <= (md_ready_i || u_stub) ? 6'd0 : u_cnt + 6'd1;
  end

  int n_mult = 0, n_div = 0, n_rspv = 0, n_both = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (md_mult_en_o)                n_mult <= n_mult + 1;
      if (md_div_en_o)                 n_div  <= n_div + 1;
      if (rsp_valid_o)                 n_rspv <= n_rspv + 1;
      if (md_mult_en_o && md_div_en_o) n_both <= n_both + 1;
    end
  end

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [1:0] eop, input logic [1:0] esm,
                      input logic [31:0] eres, input logic eerr);
    int k = 0;
    while (!req_ready_o && k < 100) begin @(negedge clk); k++; end
    chk("req_ready_wait", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_funct3_i = f3; req_op_a_i = a; req_op_b_i = b; req_tag_i = tag;
    sb.push_back('{eres, tag, eerr});
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("operator", 32'(md_operator_o), 32'(eop));
    chk("signed_mode", 32'(md_signed_mode_o), 32'(esm));
    chk("op_a_latched", md_op_a_o, a);
    chk("op_b_latched", md_op_b_o, b);
    chk("eq_zero", 32'(md_equal_to_zero_o), 32'(b == 32'd0));
  endtask

  task automatic get_rsp(input int budget);
    int k = 0;
    exp_t e;
    rsp_ready_i = 1'b1;
    while (!rsp_valid_o && k < budget) begin @(negedge clk); k++; end
    chk("rsp_seen", 32'(rsp_valid_o), 32'd1);
    if (rsp_valid_o && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_result", rsp_result_o, e.res);
      chk("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
      chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
    end
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int m0, d0, r0, k;
    exp_t e;
    req_valid_i = 1'b0; req_funct3_i = 3'd0; req_op_a_i = 32'd0; req_op_b_i = 32'd0;
    req_tag_i = '0; kill_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_mult_en", 32'(md_mult_en_o), 32'd0);
    chk("rst_div_en", 32'(md_div_en_o), 32'd0);
    chk("rst_op_a", md_op_a_o, 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);
    chk("rst_tag_err", {27'd0, rsp_tag_o, rsp_err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    m0 = n_mult;
    send(3'b000, 32'd7, 32'hFFFF_FFFD, 4'h5, 2'd0, 2'b00, 32'hFFFF_FFEB, 1'b0);
    get_rsp(50);
    chk("mul_en_cycles", n_mult - m0, 32'd3);

    m0 = n_mult;
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h6, 2'd1, 2'b00, 32'hFFFF_FFFE, 1'b0);
    get_rsp(50);
    chk("mulh_en_cycles", n_mult - m0, 32'd4);
    send(3'b010, 32'hFFFF_FFFF, 32'd2, 4'h7, 2'd1, 2'b01, 32'hFFFF_FFFF, 1'b0);
    get_rsp(50);
    send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 2'd1, 2'b11, 32'h0000_0000, 1'b0);
    get_rsp(50);

    d0 = n_div;
    send(3'b100, 32'hFFFF_FFEC, 32'd6, 4'h9, 2'd2, 2'b11, 32'hFFFF_FFFD, 1'b0);
    get_rsp(80);
    chk("div_en_cycles", n_div - d0, 32'd37);
    send(3'b110, 32'hFFFF_FFEC, 32'd6, 4'hA, 2'd3, 2'b11, 32'hFFFF_FFFE, 1'b0);
    get_rsp(80);

    d0 = n_div;
    send(3'b101, 32'd5, 32'd0, 4'hB, 2'd2, 2'b00, 32'hFFFF_FFFF, 1'b0);
    get_rsp(20);
    chk("divz_en_cycles", n_div - d0, 32'd2);
    d0 = n_div;
    send(3'b111, 32'd5, 32'd0, 4'hC, 2'd3, 2'b00, 32'h0000_0005, 1'b0);
    get_rsp(20);
    chk("remz_en_cycles", n_div - d0, 32'd2);

    // kill on the 10th enabled cycle of a divide
    d0 = n_div; r0 = n_rspv;
    send(3'b100, 32'd1000, 32'd7, 4'hD, 2'd2, 2'b11, 32'd142, 1'b0);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("drain_en_held", 32'(md_div_en_o), 32'd1);
    k = 0;
    while (md_div_en_o && k < 60) begin @(negedge clk); k++; end
    chk("drain_done", 32'(md_div_en_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("kill_div_cycles", n_div - d0, 32'd37);
    chk("kill_no_rsp", n_rspv - r0, 32'd0);
    chk("kill_idle_ready", 32'(req_ready_o), 32'd1);
    send(3'b000, 32'd3, 32'd4, 4'hE, 2'd0, 2'b00, 32'd12, 1'b0);
    get_rsp(50);

    // backpressure then same-cycle response/request handshake
    send(3'b000, 32'd9, 32'd9, 4'hA, 2'd0, 2'b00, 32'h51, 1'b0);
    rsp_ready_i = 1'b0;
    k = 0;
    while (!rsp_valid_o && k < 50) begin @(negedge clk); k++; end
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_result", rsp_result_o, e.res);
      chk("bp_tag", 32'(rsp_tag_o), 32'(e.tag));
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_funct3_i = 3'b100;
    req_op_a_i = 32'd100; req_op_b_i = 32'd7; req_tag_i = 4'hB;
    void'(sb.pop_front());
    sb.push_back('{32'd14, 4'hB, 1'b0});
    #1;
    chk("b2b_req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    chk("b2b_rsp_dropped", 32'(rsp_valid_o), 32'd0);
    chk("b2b_div_en", 32'(md_div_en_o), 32'd1);
    chk("b2b_op_a", md_op_a_o, 32'd100);
    get_rsp(80);

    // kill during response, then kill racing a request in IDLE
    send(3'b000, 32'd2, 32'd3, 4'h1, 2'd0, 2'b00, 32'd6, 1'b0);
    k = 0;
    while (!rsp_valid_o && k < 50) begin @(negedge clk); k++; end
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    void'(sb.pop_front());
    chk("resp_kill_valid", 32'(rsp_valid_o), 32'd0);
    kill_i = 1'b1; req_valid_i = 1'b1; req_funct3_i = 3'b000;
    #1;
    chk("kill_req_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    kill_i = 1'b0; req_valid_i = 1'b0;
    chk("kill_req_mult_en", 32'(md_mult_en_o), 32'd0);
    chk("kill_req_div_en", 32'(md_div_en_o), 32'd0);

    // watchdog with a unit that never finishes
    u_stub = 1'b1;
    m0 = n_mult;
    send(3'b000, 32'd11, 32'd13, 4'h3, 2'd0, 2'b00, 32'd0, 1'b1);
    get_rsp(200);
    chk("tmo_en_cycles", n_mult - m0, TIMEOUT);
    u_stub = 1'b0;

    // reset mid-operation
    send(3'b101, 32'd1000, 32'd3, 4'h9, 2'd2, 2'b00, 32'd333, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_div_en", 32'(md_div_en_o), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("mid_rst_op_a", md_op_a_o, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'b000, 32'd6, 32'd7, 4'hC, 2'd0, 2'b00, 32'd42, 1'b0);
    get_rsp(50);

    chk("never_both_en", n_both, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_sequencer.md
Name: ibex_multdiv_sequencer

Overview:
- Front-end controller for the fast multiply/divide unit.
- Accepts RV32M requests over a valid/ready handshake, decodes funct3 into the unit's operator and signed-mode controls, and holds operands stable.
- Drives the mult/div enables until the unit reports ready, captures the result and returns it with a tag over a second valid/ready handshake.
- Supports kill (flush) with safe draining and a watchdog timeout.

Parameters:
- TAG_W, 4: width of the request/response tag.
- TIMEOUT, 64: max cycles in BUSY/DRAIN before the error response (must be > 40).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_funct3_i  in  3  RV32M funct3
- req_op_a_i  in  32  operand a
- req_op_b_i  in  32  operand b
- req_tag_i  in  TAG_W  request tag
- kill_i  in  1  discard the in-flight op
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_result_o  out  32  result
- rsp_tag_o  out  TAG_W  tag of the response
- rsp_err_o  out  1  timeout occurred (result = 0)
- md_mult_en_o  out  1  unit multiply enable
- md_div_en_o  out  1  unit divide enable
- md_operator_o  out  2  0 MULL, 1 MULH, 2 DIV, 3 REM
- md_signed_mode_o  out  2  [0] a signed, [1] b signed
- md_op_a_o  out  32  latched operand a
- md_op_b_o  out  32  latched operand b
- md_equal_to_zero_o  out  1  latched op_b == 0
- md_ready_i  in  1  unit done this cycle
- md_result_i  in  32  unit result, valid when md_ready_i

Behaviour:
- Decode (registered at accept):
  - 000 -> MULL/00
  - 001 -> MULH/11
  - 010 -> MULH/01
  - 011 -> MULH/00
  - 100 -> DIV/11
  - 101 -> DIV/00
  - 110 -> REM/11
  - 111 -> REM/00
- mult_en is asserted for operator 0/1; div_en for 2/3. Never both.
- Reset values:
  - State IDLE.
  - All outputs 0 except req_ready_o = 1.
  - Operand, tag and result registers 0.
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - On accept: latch operands, tag, decoded controls and equal_to_zero; go to BUSY.
  - Enables rise the cycle after accept.
- BUSY:
  - The selected enable is held high every cycle.
  - On md_ready_i: capture md_result_i and go to RESP.
  - The enable stays high in the md_ready_i cycle, because the unit advances FINISH->IDLE and ALBL wrap only when enabled. It drops the following cycle.
- RESP:
  - rsp_valid_o = 1; result and tag are stable until rsp_ready_i.
  - On rsp_ready_i: go to IDLE.
  - req_ready_o = rsp_ready_i, so back-to-back accept is allowed (RESP->BUSY directly).
- Kill:
  - kill_i in BUSY -> DRAIN. The enable stays high until md_ready_i, then go to IDLE with no response. This leaves the unit in its idle state.
  - kill_i in RESP drops the response (-> IDLE).
  - kill_i in IDLE/DRAIN has no effect.
  - kill_i together with req_valid_i in IDLE: kill has priority and the request is not accepted.
- Watchdog:
  - A cycle counter clears on entering BUSY and saturates.
  - If it reaches TIMEOUT in BUSY: respond with rsp_err_o = 1, result 0, and go to RESP.
  - If it reaches TIMEOUT in DRAIN: go to IDLE.
  - In both cases the enables drop.
- Expected unit latencies, from the first enabled cycle to md_ready_i inclusive:
  - MUL: 3
  - MULH*: 4
  - DIV/REM: 37
  - Divide by zero: 2
- Reset mid-operation: returns to IDLE immediately and discards everything. The unit is reset by the same rst_n.
- Operands and controls to the unit must not change while either enable is high.

Decomposition:
- Shared package: MD operator constants (MULL/MULH/DIV/REM), sequencer state enum, funct3 constants.
- Natural sub-module: ibex_multdiv_decode, a combinational funct3 -> operator/signed_mode/is_div decoder, reused by the decoder stage.

Test Plan:
- MUL (000): a=7, b=-3 -> rsp_result = 0xFFFFFFEB; mult_en high exactly 3 cycles; tag echoed.
- MULHU (011): a = b = 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU (010): a=-1, b=2 -> 0xFFFFFFFF.
- DIV (100): a=-20, b=6 -> 0xFFFFFFFD. REM: same operands -> 0xFFFFFFFE. div_en high 37 cycles.
- Divide by zero:
  - DIVU: a=5, b=0 -> 0xFFFFFFFF.
  - REMU: a=5, b=0 -> 0x00000005.
  - md_equal_to_zero_o = 1; 2-cycle busy.
- Kill at cycle 10 of DIV -> div_en held until md_ready_i, no rsp_valid. Then MUL 3×4 -> 12 is correct, proving the unit is clean.
- Backpressure: rsp_ready_i low for 5 cycles -> result and tag stable, req_ready_o low. Then a same-cycle rsp_ready_i with a new req is accepted. A stubbed unit with md_ready_i stuck low -> rsp_err_o = 1 at TIMEOUT.
